// File: rtl/gpcore_pkg.sv
// Shared types for the instruction fetch front end: fetch queue entry,
// fetch state encoding and the canonical NOP used for faulted entries.
package gpcore_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_HALTED,
        FS_FAULTED
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched entries between memory response and decode.
// Ports: push/push_data in, pop in, clear in, head/count/full/empty out.
module fetch_fifo
    import gpcore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_idx;
    logic            do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = mem[rd_ptr];
    assign do_pop = pop & ~empty & ~clear;
    // A clear restarts the queue at slot 0; a push in the same
    // cycle becomes the sole surviving entry.
    assign wr_idx = clear ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: sequential word fetch, credit-limited issue, in-order queue.
// Ports: imem_* memory side, redirect/halt control, instr_* decode side.
module instr_fetch_unit
    import gpcore_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        dec_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [11:0] funct12,
    output logic        instr_30,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = 8;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [DW-1:0] discard;

    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    fetch_entry_t  q_head;
    fetch_entry_t  push_entry;
    logic          q_push;
    logic          q_pop;

    logic          redir_bad;
    logic          credit_ok;
    logic          issued;
    logic          resp_drop;
    logic          resp_keep;

    assign redir_bad = redirect & is_misaligned(redirect_pc);
    // Queue slots already taken plus responses still owed must leave room.
    assign credit_ok = ({1'b0, q_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    assign imem_req  = (state == FS_RUN) & ~redirect & credit_ok;
    assign imem_addr = fetch_pc;
    assign issued    = imem_req & imem_gnt;

    assign resp_drop = imem_rvalid & (discard != '0);
    assign resp_keep = imem_rvalid & (discard == '0) & ~redirect;

    // Responses return in order, so resp_pc tracks the next kept response.
    always_comb begin
        push_entry = '0;
        if (redirect) begin
            push_entry = '{instr: NOP_INSTR, pc: redirect_pc, fault: 1'b1};
        end else begin
            push_entry.instr = imem_err ? NOP_INSTR : imem_rdata;
            push_entry.pc    = resp_pc;
            push_entry.fault = imem_err;
        end
    end

    assign q_push = resp_keep | redir_bad;
    assign q_pop  = instr_valid & dec_ready & ~redirect;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .clear     (redirect),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_BOOT;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            case (state)
                FS_BOOT: begin
                    state <= redir_bad ? FS_FAULTED : FS_RUN;
                end
                FS_RUN, FS_HALTED: begin
                    if (redir_bad) begin
                        state <= FS_FAULTED;
                    end else begin
                        state <= halt ? FS_HALTED : FS_RUN;
                    end
                end
                FS_FAULTED: begin
                    if (redirect && !redir_bad) begin
                        state <= halt ? FS_HALTED : FS_RUN;
                    end
                end
                default: state <= FS_BOOT;
            endcase

            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                inflight <= '0;
                // Everything still owed by memory is now stale; a response
                // arriving this very cycle is one of them.
                discard  <= discard + DW'(inflight) - DW'(imem_rvalid);
            end else begin
                if (issued) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                inflight <= inflight + CW'(issued) - CW'(resp_keep);
                if (resp_drop) begin
                    discard <= discard - DW'(1);
                end
            end
        end
    end

    assign instr_valid = ~q_empty;
    assign instr       = q_empty ? NOP_INSTR : q_head.instr;
    assign instr_pc    = q_empty ? 32'h0 : q_head.pc;
    assign fetch_fault = ~q_empty & q_head.fault;

    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign funct12  = instr[31:20];
    assign instr_30 = instr[30];

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(q_push && q_full && !q_pop && !redirect)
    );

endmodule
